// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register map, status bit indices and reset defaults
// shared by the UART receive-FIFO bus controller.
package uart_ctrl_pkg;

  localparam logic [31:0] ADDR_DATA    = 32'h00;
  localparam logic [31:0] ADDR_VALID   = 32'h04;
  localparam logic [31:0] ADDR_BUSY    = 32'h08;
  localparam logic [31:0] ADDR_BAUD    = 32'h0C;
  localparam logic [31:0] ADDR_PARITY  = 32'h10;
  localparam logic [31:0] ADDR_STOPBIT = 32'h14;
  localparam logic [31:0] ADDR_LEVEL   = 32'h18;
  localparam logic [31:0] ADDR_THRESH  = 32'h1C;
  localparam logic [31:0] ADDR_STATUS  = 32'h20;
  localparam logic [31:0] ADDR_RST     = 32'h24;

  localparam int STAT_OVERRUN = 0;
  localparam int STAT_IRQ_EN  = 1;

  localparam int   BAUD_W        = 17;
  localparam logic RST_PARITY_EN = 1'b1;
  localparam logic RST_STOPBIT   = 1'b1;
  localparam logic RST_IRQ_EN    = 1'b1;

  // Threshold is kept in 1..depth so the IRQ can always fire.
  function automatic logic [31:0] clamp_thresh(
    input logic [31:0] v,
    input logic [31:0] depth
  );
    logic [31:0] r;
    r = v;
    if (v == 32'd0) r = 32'd1;
    else if (v > depth) r = depth;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, combinational head, level counter.
// Ports: push/pop/din in; dout/full/empty/level out. Pop+push at full ok.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot this cycle, so a push at full still fits.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit receiver, even parity optional, stopbit_i=1 -> 2 stops.
// Ports: rx_i, baudrate_i (bits/s), rx_data_o/rx_valid_o pulse, busy_o.
module uart_rx #(
  parameter int unsigned CLK_HZ = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [16:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state;
  logic [1:0]  sync;
  logic        rx_s;
  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic        tick;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        par;
  logic        par_ok;
  logic        stop2;

  assign rx_s    = sync[1];
  // Phase accumulator: one tick per bit period, no divider needed.
  assign acc_sum = acc + {15'd0, baudrate_i};
  assign tick    = (acc_sum >= CLK_HZ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      sync       <= 2'b11;
      acc        <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      par_ok     <= 1'b1;
      stop2      <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      sync       <= {sync[0], rx_i};
      rx_valid_o <= 1'b0;
      if (state == S_IDLE) begin
        if (!rx_s) begin
          // Half-period preload puts every tick mid-bit.
          state  <= S_START;
          acc    <= 32'(CLK_HZ / 2);
          busy_o <= 1'b1;
        end
      end else begin
        acc <= tick ? acc_sum - CLK_HZ : acc_sum;
        if (tick) begin
          unique case (state)
            S_START: begin
              if (rx_s) begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
              end else begin
                state   <= S_DATA;
                bit_cnt <= '0;
                par     <= 1'b0;
              end
            end
            S_DATA: begin
              shreg   <= {rx_s, shreg[7:1]};
              par     <= par ^ rx_s;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state  <= parity_en_i ? S_PARITY : S_STOP;
                par_ok <= 1'b1;
                stop2  <= 1'b0;
              end
            end
            S_PARITY: begin
              par_ok <= (par == rx_s);
              state  <= S_STOP;
            end
            S_STOP: begin
              if (!stop2) begin
                if (rx_s && par_ok) begin
                  rx_valid_o <= 1'b1;
                  rx_data_o  <= shreg;
                end
                if (stopbit_i && rx_s) begin
                  stop2 <= 1'b1;
                end else begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
                end
              end else begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
              end
            end
            default: begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo_sb_ctrl.sv
// uart_rx_fifo_sb_ctrl: bus-mapped UART RX with FIFO, threshold IRQ, overrun.
// Ports: clk_i/rst_i, req/addr/we/wdata -> read_data_o, irq req/return, rx_i.
import uart_ctrl_pkg::*;

module uart_rx_fifo_sb_ctrl #(
  parameter int          FIFO_DEPTH        = 16,
  parameter logic [16:0] DEFAULT_BAUD      = 17'd9600,
  parameter int          DEFAULT_THRESHOLD = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] write_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  input  logic        rx_i
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              rd;
  logic              wr;
  logic              srst;
  logic              rst_all;
  logic              rx_valid;
  logic              rx_busy;
  logic [7:0]        rx_data;
  logic              busy_q;
  logic [BAUD_W-1:0] baud;
  logic              parity_en;
  logic              stopbit;
  logic              irq_en;
  logic              overrun;
  logic              irq_pend;
  logic [LW-1:0]     thresh;
  logic [LW-1:0]     level;
  logic [LW-1:0]     level_next;
  logic [7:0]        head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              pop_ok;
  logic              push_ok;
  logic              ovr_set;
  logic              ovr_clr;
  logic              irq_en_n;
  logic              overrun_n;
  logic              irq_set;
  logic              irq_clr;
  logic              irq_pend_n;
  logic [31:0]       rdata;

  assign rd      = req_i & ~write_enable_i;
  assign wr      = req_i & write_enable_i;
  assign srst    = wr & (addr_i == ADDR_RST) & write_data_i[0];
  assign rst_all = rst_i | srst;

  uart_rx u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_all),
    .rx_i        (rx_i),
    .baudrate_i  (baud),
    .parity_en_i (parity_en),
    .stopbit_i   (stopbit),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .busy_o      (rx_busy)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_all),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign pop        = rd & (addr_i == ADDR_DATA);
  assign pop_ok     = pop & ~empty;
  assign push_ok    = rx_valid & (~full | pop_ok);
  assign ovr_set    = rx_valid & full & ~pop_ok;
  assign level_next = level + LW'(push_ok) - LW'(pop_ok);

  always_comb begin
    irq_en_n = irq_en;
    ovr_clr  = 1'b0;
    if (wr && addr_i == ADDR_STATUS) begin
      irq_en_n = write_data_i[STAT_IRQ_EN];
      ovr_clr  = write_data_i[STAT_OVERRUN];
    end
    overrun_n  = ovr_set | (overrun & ~ovr_clr);
    irq_set    = (push_ok & (level_next >= thresh))
               | (ovr_set & ~overrun);
    irq_clr    = interrupt_return_i
               | ((level_next < thresh) & ~overrun_n);
    // Set beats clear; disabling masks it from the next cycle on.
    irq_pend_n = irq_en_n & (irq_set | (irq_pend & ~irq_clr));
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr_i == ADDR_DATA:    rdata = {24'd0, empty ? 8'd0 : head};
      addr_i == ADDR_VALID:   rdata = {31'd0, ~empty};
      addr_i == ADDR_BUSY:    rdata = {31'd0, busy_q};
      addr_i == ADDR_BAUD:    rdata = 32'(baud);
      addr_i == ADDR_PARITY:  rdata = {31'd0, parity_en};
      addr_i == ADDR_STOPBIT: rdata = {31'd0, stopbit};
      addr_i == ADDR_LEVEL:   rdata = 32'(level);
      addr_i == ADDR_THRESH:  rdata = 32'(thresh);
      addr_i == ADDR_STATUS:  rdata = {30'd0, irq_en, overrun};
      default:                rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      read_data_o <= '0;
      busy_q      <= 1'b0;
      baud        <= DEFAULT_BAUD;
      parity_en   <= RST_PARITY_EN;
      stopbit     <= RST_STOPBIT;
      thresh      <= LW'(DEFAULT_THRESHOLD);
      irq_en      <= RST_IRQ_EN;
      overrun     <= 1'b0;
      irq_pend    <= 1'b0;
    end else begin
      read_data_o <= rd ? rdata : '0;
      busy_q      <= rx_busy;
      irq_en      <= irq_en_n;
      overrun     <= overrun_n;
      irq_pend    <= irq_pend_n;
      if (wr && addr_i == ADDR_THRESH) begin
        thresh <= LW'(clamp_thresh(write_data_i, 32'(FIFO_DEPTH)));
      end
      // Line config is frozen while a frame is in flight.
      if (wr && !busy_q) begin
        if (addr_i == ADDR_BAUD)    baud      <= write_data_i[BAUD_W-1:0];
        if (addr_i == ADDR_PARITY)  parity_en <= write_data_i[0];
        if (addr_i == ADDR_STOPBIT) stopbit   <= write_data_i[0];
      end
    end
  end

  assign interrupt_request_o = irq_pend;

endmodule

// File: tb/tb_uart_rx_fifo_sb_ctrl.sv
// tb_uart_rx_fifo_sb_ctrl: scenario tasks with random bytes, checked
// against a queue model of FIFO contents, overrun and IRQ level.
module tb_uart_rx_fifo_sb_ctrl;
  import uart_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        irq;
  logic        irq_ret = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail = 0;
  int bit_cycles = 104;

  logic [7:0] q[$];
  bit         m_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_sb_ctrl #(
    .FIFO_DEPTH        (DEPTH),
    .DEFAULT_BAUD      (17'd9600),
    .DEFAULT_THRESHOLD (1)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .addr_i              (addr),
    .req_i               (req),
    .write_data_i        (wdata),
    .write_enable_i      (we),
    .read_data_o         (rdata),
    .interrupt_request_o (irq),
    .interrupt_return_i  (irq_ret),
    .rx_i                (rx)
  );

  function automatic void m_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; we = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    d = rdata;
  endtask

  // start, 8 data LSB first, even parity, two stop bits
  task automatic send_byte(input logic [7:0] b);
    logic [11:0] fr;
    fr = {2'b11, ^b, b, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx = fr[i];
      repeat (bit_cycles - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] ra [11];
    logic [31:0] re [11];
    ra = '{ADDR_BAUD, ADDR_PARITY, ADDR_STOPBIT, ADDR_LEVEL, ADDR_THRESH,
           ADDR_STATUS, ADDR_VALID, ADDR_BUSY, ADDR_DATA, 32'h28, 32'h40};
    re = '{32'd9600, 32'd1, 32'd1, 32'd0, 32'd1, 32'h2, 32'd0, 32'd0,
           32'd0, 32'd0, 32'd0};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (rdata !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs rdata=%0h irq=%0b required 0/0", rdata, irq);
    end
    for (int i = 0; i < 11; i++) begin
      bus_read(ra[i], v);
      n_tests++;
      if (v !== re[i]) begin
        n_fail++;
        $display("FAIL reset_reg[%0h] got %0h required %0h", ra[i], v, re[i]);
      end
    end
  endtask

  task automatic test_default_rx();
    logic [31:0] v;
    logic [7:0]  b [3];
    b = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) begin
      send_byte(b[i]);
      m_push(b[i]);
      if (i == 0) begin
        n_tests++;
        if (irq !== 1'b1) begin
          n_fail++;
          $display("FAIL irq_first_byte got %0b required 1", irq);
        end
      end
    end
    bus_read(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'(q.size())) begin
      n_fail++;
      $display("FAIL default_level got %0d required %0d", v, q.size());
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(ADDR_DATA, v);
      n_tests++;
      if (v !== {24'd0, q[0]}) begin
        n_fail++;
        $display("FAIL default_data%0d got %0h required %0h", i, v, q[0]);
      end
      void'(q.pop_front());
    end
    bus_read(ADDR_VALID, v);
    n_tests++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL drained valid=%0d irq=%0b required 0/0", v, irq);
    end
  endtask

  task automatic test_baud_busy();
    logic [31:0] v;
    logic [31:0] vb;
    logic [31:0] vd;
    v = '0; vb = '0;
    fork
      send_byte(8'h5A);
      begin
        repeat (300) @(negedge clk);
        bus_read(ADDR_BUSY, vb);
        bus_write(ADDR_BAUD, 32'd115200);
        bus_read(ADDR_BAUD, v);
      end
    join
    m_push(8'h5A);
    n_tests++;
    if (vb !== 32'd1 || v !== 32'd9600) begin
      n_fail++;
      $display("FAIL baud_busy busy=%0d baud=%0d required 1/9600", vb, v);
    end
    repeat (20) @(negedge clk);
    bus_write(ADDR_BAUD, 32'd115200);
    bus_read(ADDR_BAUD, v);
    n_tests++;
    if (v !== 32'd115200) begin
      n_fail++;
      $display("FAIL baud_idle got %0d required 115200", v);
    end
    bus_write(ADDR_BAUD, 32'd62500);
    bit_cycles = 16;
    bus_read(ADDR_DATA, vd);
    n_tests++;
    if (vd !== {24'd0, q[0]}) begin
      n_fail++;
      $display("FAIL baud_busy_data got %0h required %0h", vd, q[0]);
    end
    void'(q.pop_front());
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    logic [7:0]  b;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_byte(b);
      m_push(b);
    end
    bus_read(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'(q.size())) begin
      n_fail++;
      $display("FAIL ovr_level got %0d required %0d", v, q.size());
    end
    bus_read(ADDR_STATUS, v);
    n_tests++;
    if (v !== {30'd0, 1'b1, m_ovr} || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_status got %0h irq=%0b required %0h/1", v, irq, {1'b1, m_ovr});
    end
    while (q.size() > 0) begin
      bus_read(ADDR_DATA, v);
      n_tests++;
      if (v !== {24'd0, q[0]}) begin
        n_fail++;
        $display("FAIL ovr_data got %0h required %0h", v, q[0]);
      end
      void'(q.pop_front());
    end
    bus_write(ADDR_STATUS, 32'h1);
    m_ovr = 1'b0;
    bus_read(ADDR_STATUS, v);
    n_tests++;
    if (v !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear got %0h irq=%0b required 0/0", v, irq);
    end
    bus_write(ADDR_STATUS, 32'h2);
  endtask

  task automatic test_threshold();
    logic [31:0] v;
    logic [7:0]  b;
    bus_write(ADDR_THRESH, 32'd3);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_byte(b);
      m_push(b);
      n_tests++;
      if (irq !== (q.size() >= 3)) begin
        n_fail++;
        $display("FAIL thresh_irq n=%0d got %0b required %0b", q.size(), irq, q.size() >= 3);
      end
    end
    @(negedge clk);
    irq_ret = 1'b1;
    @(negedge clk);
    irq_ret = 1'b0;
    bus_read(ADDR_LEVEL, v);
    n_tests++;
    if (irq !== 1'b0 || v !== 32'd3) begin
      n_fail++;
      $display("FAIL irq_return irq=%0b level=%0d required 0/3", irq, v);
    end
    while (q.size() > 0) begin
      bus_read(ADDR_DATA, v);
      n_tests++;
      if (v !== {24'd0, q[0]}) begin
        n_fail++;
        $display("FAIL thresh_data got %0h required %0h", v, q[0]);
      end
      void'(q.pop_front());
    end
    bus_write(ADDR_THRESH, 32'd1);
  endtask

  task automatic test_thresh_clamp();
    logic [31:0] v;
    logic [31:0] wv [3];
    logic [31:0] ev [3];
    wv = '{32'd0, 32'd100, 32'd1};
    ev = '{32'd1, 32'(DEPTH), 32'd1};
    for (int i = 0; i < 3; i++) begin
      bus_write(ADDR_THRESH, wv[i]);
      bus_read(ADDR_THRESH, v);
      n_tests++;
      if (v !== ev[i]) begin
        n_fail++;
        $display("FAIL thresh_clamp wrote %0d got %0d required %0d", wv[i], v, ev[i]);
      end
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  b5;
    logic [7:0]  head;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_byte(b);
      m_push(b);
    end
    b5 = 8'($urandom);
    head = q[0];
    fork
      send_byte(b5);
      begin
        int k;
        k = 0;
        while (dut.u_rx.rx_valid_o !== 1'b1 && k < 4000) begin
          @(negedge clk);
          k++;
        end
        n_tests++;
        if (k >= 4000) begin
          n_fail++;
          $display("FAIL pushpop_timeout got no rx_valid required pulse");
        end else begin
          addr = ADDR_DATA; we = 1'b0; req = 1'b1;
          @(negedge clk);
          req = 1'b0;
          if (rdata !== {24'd0, head}) begin
            n_fail++;
            $display("FAIL pushpop_head got %0h required %0h", rdata, head);
          end
        end
      end
    join
    void'(q.pop_front());
    m_push(b5);
    bus_read(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'(DEPTH)) begin
      n_fail++;
      $display("FAIL pushpop_level got %0d required %0d", v, DEPTH);
    end
    bus_read(ADDR_STATUS, v);
    n_tests++;
    if (v !== 32'h2) begin
      n_fail++;
      $display("FAIL pushpop_status got %0h required 2", v);
    end
    while (q.size() > 0) begin
      bus_read(ADDR_DATA, v);
      n_tests++;
      if (v !== {24'd0, q[0]}) begin
        n_fail++;
        $display("FAIL pushpop_data got %0h required %0h", v, q[0]);
      end
      void'(q.pop_front());
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  e;
    int          nb;
    int          nr;
    for (int r = 0; r < 6; r++) begin
      nb = int'($urandom_range(0, 3));
      nr = int'($urandom_range(0, 4));
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        send_byte(b);
        m_push(b);
      end
      for (int i = 0; i < nr; i++) begin
        e = (q.size() > 0) ? q.pop_front() : 8'd0;
        bus_read(ADDR_DATA, v);
        n_tests++;
        if (v !== {24'd0, e}) begin
          n_fail++;
          $display("FAIL rand_data r=%0d got %0h required %0h", r, v, e);
        end
      end
      bus_read(ADDR_STATUS, v);
      n_tests++;
      if (v !== {30'd0, 1'b1, m_ovr} || irq !== (q.size() > 0 || m_ovr)) begin
        n_fail++;
        $display("FAIL rand_status r=%0d got %0h irq=%0b required %0h/%0b",
                 r, v, irq, {1'b1, m_ovr}, (q.size() > 0 || m_ovr));
      end
      bus_read(ADDR_LEVEL, v);
      n_tests++;
      if (v !== 32'(q.size())) begin
        n_fail++;
        $display("FAIL rand_level r=%0d got %0d required %0d", r, v, q.size());
      end
      if (m_ovr && $urandom_range(0, 1) == 1) begin
        bus_write(ADDR_STATUS, 32'h3);
        m_ovr = 1'b0;
      end
    end
  endtask

  task automatic test_soft_reset();
    logic [31:0] v;
    logic [31:0] vb;
    logic [3:0]  part;
    while (q.size() > 0) begin
      bus_read(ADDR_DATA, v);
      void'(q.pop_front());
    end
    send_byte(8'hC3);
    send_byte(8'h3C);
    part = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = part[i];
      repeat (bit_cycles - 1) @(negedge clk);
    end
    rx = 1'b1;
    bus_write(ADDR_RST, 32'h1);
    q.delete();
    m_ovr = 1'b0;
    bus_read(ADDR_LEVEL, v);
    bus_read(ADDR_BAUD, vb);
    n_tests++;
    if (v !== 32'd0 || vb !== 32'd9600 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_reset level=%0d baud=%0d irq=%0b required 0/9600/0", v, vb, irq);
    end
    repeat (2000) @(negedge clk);
    bus_read(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL soft_reset_partial level=%0d required 0", v);
    end
  endtask

  initial begin
    test_reset();
    test_default_rx();
    test_baud_busy();
    test_overrun();
    test_threshold();
    test_thresh_clamp();
    test_full_pushpop();
    test_random();
    test_soft_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
